pipe_reg_file: RTL and testbench
================================

PIPE_REG_FILE -- requirements
Module: pipe_reg_file

Interface
REQ-001 SHALL have parameter WIDTH, default 32, data word width in bits.
REQ-002 SHALL have parameter DEPTH, default 32, number of entries; power of two, at least 2; AW = $clog2(DEPTH).
REQ-003 SHALL have parameter BYPASS, default 1; 1 = same-cycle write-to-read forwarding enabled.
REQ-004 SHALL have parameter ZERO_REG, default 1; 1 = entry 0 reads 0, is never written and is never pending.
REQ-005 SHALL have one clock and an asynchronous, active-low reset, ports as follows:
  clk_i  in  1  clock; all state updates on the rising edge
  rst_ni  in  1  asynchronous active-low reset
  clr_i  in  1  request a full sequential clear
  we3_i  in  1  write enable
  wa3_i  in  AW  write address
  wd3_i  in  WIDTH  write data
  ra1_i / ra2_i  in  AW  read addresses
  rsv_i  in  1  reserve (mark pending) request
  rsv_a_i  in  AW  reserve address
  rd1_o / rd2_o  out  WIDTH  combinational read data
  pend1_o / pend2_o  out  1  read entry awaits an outstanding write
  ready_o  out  1  high when state is READY

Function
REQ-006 SHALL implement a two-state FSM, CLEAR and READY, plus an AW-bit clear counter cnt.
REQ-007 In CLEAR, each rising edge SHALL write 0 to entry cnt and increment cnt; at cnt == DEPTH-1 the FSM SHALL go to READY, so a clear takes exactly DEPTH cycles.
REQ-008 clr_i high in READY SHALL enter CLEAR with cnt = 0 and all pending bits cleared on the same edge.
REQ-009 clr_i high in CLEAR SHALL restart cnt at 0.
REQ-010 While in CLEAR, we3_i and rsv_i SHALL be ignored, and rd1_o, rd2_o, pend1_o and pend2_o SHALL read 0.
REQ-011 A write is accepted when ready_o = 1, we3_i = 1, and (ZERO_REG = 0 or wa3_i != 0); an accepted write stores wd3_i at wa3_i on the rising edge.
REQ-012 rdN_o SHALL be 0 when ZERO_REG = 1 and raN_i = 0.
REQ-013 Otherwise, rdN_o SHALL equal wd3_i when BYPASS = 1 and an accepted write has wa3_i == raN_i.
REQ-014 Otherwise, rdN_o SHALL equal the stored entry raN_i.
REQ-015 A reserve is accepted when ready_o = 1, rsv_i = 1, and (ZERO_REG = 0 or rsv_a_i != 0); it sets pending[rsv_a_i] on the rising edge.
REQ-016 An accepted write SHALL clear pending[wa3_i] on the rising edge.
REQ-017 A reserve and a write to the same address in the same cycle SHALL leave that bit set (reserve wins).
REQ-018 pendN_o SHALL equal pending[raN_i].
REQ-019 pendN_o SHALL be forced to 0 when BYPASS = 1 and an accepted write hits raN_i in the same cycle.
REQ-020 Both read ports SHALL operate independently and may address the same entry.

Reset
REQ-021 rst_ni low SHALL asynchronously force state = CLEAR, cnt = 0, all pending = 0, and ready_o = 0.
REQ-022 Storage contents SHALL NOT be reset directly; they are zeroed by the post-reset CLEAR sequence.
REQ-023 Reset asserted mid-CLEAR or mid-operation SHALL abort and restart the clear at entry 0.
REQ-024 After rst_ni deasserts, ready_o SHALL rise after exactly DEPTH rising edges.

Verification (WIDTH = 32, DEPTH = 32, BYPASS = 1, ZERO_REG = 1)
REQ-025 Reset release, then count edges -> ready_o = 0 for 32 edges, then 1; reads of entries 1..31 all return 0.
REQ-026 Write 0xDEADBEEF to entry 5, ra1_i = 5 in the same cycle -> rd1_o = 0xDEADBEEF that cycle; next cycle, with we3_i = 0, rd1_o = 0xDEADBEEF.
REQ-027 Write 0x12345678 to entry 0 -> rd1_o with ra1_i = 0 stays 0; rsv_i with rsv_a_i = 0 -> pend1_o stays 0.
REQ-028 Reserve entry 7 -> pend2_o = 1 with ra2_i = 7; write to 7 -> pend2_o = 0 in the write cycle (bypass) and after it; reserve plus write to 7 in the same cycle -> pend2_o = 1 next cycle.
REQ-029 Load entries 3 and 9, pulse clr_i -> ready_o = 0 for 32 cycles, writes during the clear are dropped, then entries 3 and 9 read 0.
REQ-030 Pulse rst_ni low at clear cycle 10 -> cnt restarts; ready_o rises 32 edges after the release.

Source files
------------

// File: rtl/pipe_reg_file.sv
// Register file with a sequential clear engine, per-entry pending (scoreboard) bits,
// optional write-to-read forwarding and an optional hardwired zero entry.
module pipe_reg_file #(
  parameter int WIDTH    = 32,
  parameter int DEPTH    = 32,
  parameter int BYPASS   = 1,
  parameter int ZERO_REG = 1,
  localparam int AW      = $clog2(DEPTH)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clr_i,
  input  logic             we3_i,
  input  logic [AW-1:0]    wa3_i,
  input  logic [WIDTH-1:0] wd3_i,
  input  logic [AW-1:0]    ra1_i,
  input  logic [AW-1:0]    ra2_i,
  input  logic             rsv_i,
  input  logic [AW-1:0]    rsv_a_i,
  output logic [WIDTH-1:0] rd1_o,
  output logic [WIDTH-1:0] rd2_o,
  output logic             pend1_o,
  output logic             pend2_o,
  output logic             ready_o
);

  typedef enum logic [0:0] {
    ST_CLEAR = 1'b0,
    ST_READY = 1'b1
  } state_e;

  localparam logic [AW-1:0]    CNT_LAST = AW'(DEPTH - 1);
  localparam logic [AW-1:0]    ADDR_0   = {AW{1'b0}};
  localparam logic [DEPTH-1:0] ONE_HOT0 = {{(DEPTH-1){1'b0}}, 1'b1};
  localparam logic             ZR       = (ZERO_REG != 0);
  localparam logic             BP       = (BYPASS != 0);

  state_e           state_q, state_d;
  logic [AW-1:0]    cnt_q, cnt_d;
  logic [DEPTH-1:0] pend_q, pend_d;
  logic [WIDTH-1:0] mem_q [DEPTH];

  logic             mem_we_d;
  logic [AW-1:0]    mem_wa_d;
  logic [WIDTH-1:0] mem_wd_d;

  logic             ready_s;
  logic             wr_acc_s;
  logic             rsv_acc_s;
  logic             hit1_s;
  logic             hit2_s;
  logic [DEPTH-1:0] pend_clr_s;
  logic [DEPTH-1:0] pend_set_s;

  // Control state: FSM, clear counter and pending bits
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_CLEAR;
      cnt_q   <= {AW{1'b0}};
      pend_q  <= {DEPTH{1'b0}};
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
    end
  end

  // Next-state logic; clr_i in either state restarts the sweep at entry 0
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_CLEAR: begin
        if (clr_i) begin
          state_d = ST_CLEAR;
          cnt_d   = {AW{1'b0}};
        end else if (cnt_q == CNT_LAST) begin
          state_d = ST_READY;
          cnt_d   = {AW{1'b0}};
        end else begin
          state_d = ST_CLEAR;
          cnt_d   = cnt_q + {{(AW-1){1'b0}}, 1'b1};
        end
      end
      ST_READY: begin
        if (clr_i) begin
          state_d = ST_CLEAR;
          cnt_d   = {AW{1'b0}};
        end else begin
          state_d = ST_READY;
          cnt_d   = cnt_q;
        end
      end
      default: begin
        state_d = ST_CLEAR;
        cnt_d   = {AW{1'b0}};
      end
    endcase
  end

  // Accept qualifiers and the pending-bit update (reserve beats write-clear)
  always_comb begin
    ready_s    = (state_q == ST_READY);
    wr_acc_s   = ready_s & we3_i & (~ZR | (wa3_i != ADDR_0));
    rsv_acc_s  = ready_s & rsv_i & (~ZR | (rsv_a_i != ADDR_0));
    pend_clr_s = wr_acc_s  ? (ONE_HOT0 << wa3_i)   : {DEPTH{1'b0}};
    pend_set_s = rsv_acc_s ? (ONE_HOT0 << rsv_a_i) : {DEPTH{1'b0}};
    if (!ready_s || clr_i) begin
      pend_d = {DEPTH{1'b0}};
    end else begin
      pend_d = (pend_q & ~pend_clr_s) | pend_set_s;
    end
  end

  // Storage write port: the clear sweep owns it while not ready
  always_comb begin
    if (!ready_s) begin
      mem_we_d = 1'b1;
      mem_wa_d = cnt_q;
      mem_wd_d = {WIDTH{1'b0}};
    end else begin
      mem_we_d = wr_acc_s;
      mem_wa_d = wa3_i;
      mem_wd_d = wd3_i;
    end
  end

  // Storage array; deliberately not reset, the clear sweep zeroes it
  always_ff @(posedge clk_i) begin
    if (mem_we_d) begin
      mem_q[mem_wa_d] <= mem_wd_d;
    end
  end

  // Read ports: clear blanking, zero entry, forwarding, then stored value
  always_comb begin
    hit1_s = BP & wr_acc_s & (wa3_i == ra1_i);
    hit2_s = BP & wr_acc_s & (wa3_i == ra2_i);

    if (!ready_s) begin
      rd1_o   = {WIDTH{1'b0}};
      pend1_o = 1'b0;
    end else if (ZR && (ra1_i == ADDR_0)) begin
      rd1_o   = {WIDTH{1'b0}};
      pend1_o = 1'b0;
    end else if (hit1_s) begin
      rd1_o   = wd3_i;
      pend1_o = 1'b0;
    end else begin
      rd1_o   = mem_q[ra1_i];
      pend1_o = pend_q[ra1_i];
    end

    if (!ready_s) begin
      rd2_o   = {WIDTH{1'b0}};
      pend2_o = 1'b0;
    end else if (ZR && (ra2_i == ADDR_0)) begin
      rd2_o   = {WIDTH{1'b0}};
      pend2_o = 1'b0;
    end else if (hit2_s) begin
      rd2_o   = wd3_i;
      pend2_o = 1'b0;
    end else begin
      rd2_o   = mem_q[ra2_i];
      pend2_o = pend_q[ra2_i];
    end
  end

  assign ready_o = ready_s;

endmodule

// File: tb/tb_pipe_reg_file.sv
// Directed bench for pipe_reg_file: expectations are queued as stimulus is driven
// and drained against the DUT outputs half a cycle later.
module tb_pipe_reg_file;

  localparam int WIDTH = 32;
  localparam int DEPTH = 32;
  localparam int AW    = 5;

  localparam int SIG_RD1   = 0;
  localparam int SIG_RD2   = 1;
  localparam int SIG_PEND1 = 2;
  localparam int SIG_PEND2 = 3;
  localparam int SIG_READY = 4;

  logic             clk = 1'b0;
  logic             rst_ni;
  logic             clr_i;
  logic             we3_i;
  logic [AW-1:0]    wa3_i;
  logic [WIDTH-1:0] wd3_i;
  logic [AW-1:0]    ra1_i;
  logic [AW-1:0]    ra2_i;
  logic             rsv_i;
  logic [AW-1:0]    rsv_a_i;
  logic [WIDTH-1:0] rd1_o;
  logic [WIDTH-1:0] rd2_o;
  logic             pend1_o;
  logic             pend2_o;
  logic             ready_o;

  always #5 clk = ~clk;

  pipe_reg_file #(
    .WIDTH   (WIDTH),
    .DEPTH   (DEPTH),
    .BYPASS  (1),
    .ZERO_REG(1)
  ) dut (
    .clk_i  (clk),
    .rst_ni (rst_ni),
    .clr_i  (clr_i),
    .we3_i  (we3_i),
    .wa3_i  (wa3_i),
    .wd3_i  (wd3_i),
    .ra1_i  (ra1_i),
    .ra2_i  (ra2_i),
    .rsv_i  (rsv_i),
    .rsv_a_i(rsv_a_i),
    .rd1_o  (rd1_o),
    .rd2_o  (rd2_o),
    .pend1_o(pend1_o),
    .pend2_o(pend2_o),
    .ready_o(ready_o)
  );

  typedef struct {
    string       tag;
    int          sig;
    logic [31:0] exp;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  task automatic push(input string tag, input int sig, input logic [31:0] e);
    exp_t x;
    x.tag = tag;
    x.sig = sig;
    x.exp = e;
    sb_q.push_back(x);
  endtask

  function automatic logic [31:0] observe(input int sig);
    case (sig)
      SIG_RD1:   observe = rd1_o;
      SIG_RD2:   observe = rd2_o;
      SIG_PEND1: observe = {31'd0, pend1_o};
      SIG_PEND2: observe = {31'd0, pend2_o};
      SIG_READY: observe = {31'd0, ready_o};
      default:   observe = 32'hFFFF_FFFF;
    endcase
  endfunction

  task automatic drain();
    exp_t        x;
    logic [31:0] o;
    while (sb_q.size() > 0) begin
      x = sb_q.pop_front();
      o = observe(x.sig);
      n_checks++;
      assert (o === x.exp) n_pass++;
      else $error("FAIL %s: observed %h expected %h", x.tag, o, x.exp);
    end
  endtask

  // Compare at the falling edge, then advance past the next rising edge.
  task automatic cycle();
    @(negedge clk);
    drain();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    clr_i   = 1'b0;
    we3_i   = 1'b0;
    wa3_i   = 5'd0;
    wd3_i   = 32'd0;
    rsv_i   = 1'b0;
    rsv_a_i = 5'd0;
  endtask

  // Count rising edges from the current point; ready must rise on exactly edge 32.
  task automatic count_ready(input string tag);
    for (int k = 1; k <= DEPTH; k++) begin
      @(posedge clk);
      #1;
      push(tag, SIG_READY, (k == DEPTH) ? 32'd1 : 32'd0);
      drain();
    end
  endtask

  initial begin
    rst_ni = 1'b0;
    idle_inputs();
    ra1_i = 5'd0;
    ra2_i = 5'd0;
    #3;
    push("reset_ready", SIG_READY, 32'd0);
    push("reset_pend1", SIG_PEND1, 32'd0);
    drain();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_ni = 1'b1;
    count_ready("post_reset_ready");

    // Every non-zero entry must read zero after the post-reset clear.
    for (int i = 1; i < DEPTH; i++) begin
      ra1_i = 5'(i);
      ra2_i = 5'(DEPTH - i);
      push("init_rd1", SIG_RD1, 32'd0);
      push("init_rd2", SIG_RD2, 32'd0);
      cycle();
    end

    // Forwarding on write, then stored value.
    we3_i = 1'b1; wa3_i = 5'd5; wd3_i = 32'hDEAD_BEEF; ra1_i = 5'd5;
    push("bypass_rd1", SIG_RD1, 32'hDEAD_BEEF);
    cycle();
    idle_inputs();
    push("stored_rd1", SIG_RD1, 32'hDEAD_BEEF);
    cycle();

    // Entry 0 ignores writes and reserves.
    we3_i = 1'b1; wa3_i = 5'd0; wd3_i = 32'h1234_5678; ra1_i = 5'd0;
    push("zero_wr_same", SIG_RD1, 32'd0);
    cycle();
    idle_inputs();
    push("zero_wr_after", SIG_RD1, 32'd0);
    rsv_i = 1'b1; rsv_a_i = 5'd0;
    push("zero_rsv_same", SIG_PEND1, 32'd0);
    cycle();
    idle_inputs();
    push("zero_rsv_after", SIG_PEND1, 32'd0);
    cycle();

    // Pending bit life cycle on entry 7, read from both ports.
    rsv_i = 1'b1; rsv_a_i = 5'd7; ra2_i = 5'd7; ra1_i = 5'd5;
    push("rsv_same_cycle", SIG_PEND2, 32'd0);
    cycle();
    idle_inputs(); ra1_i = 5'd7;
    push("rsv_pend2", SIG_PEND2, 32'd1);
    push("rsv_pend1", SIG_PEND1, 32'd1);
    cycle();
    we3_i = 1'b1; wa3_i = 5'd7; wd3_i = 32'hAAAA_5555; ra1_i = 5'd5;
    push("wr_pend2_bypass", SIG_PEND2, 32'd0);
    push("wr_rd2_bypass", SIG_RD2, 32'hAAAA_5555);
    push("port1_indep", SIG_RD1, 32'hDEAD_BEEF);
    cycle();
    idle_inputs();
    push("wr_pend2_after", SIG_PEND2, 32'd0);
    push("wr_rd2_after", SIG_RD2, 32'hAAAA_5555);
    cycle();
    rsv_i = 1'b1; rsv_a_i = 5'd7; we3_i = 1'b1; wa3_i = 5'd7; wd3_i = 32'h0BAD_F00D;
    push("rsv_wr_same", SIG_PEND2, 32'd0);
    cycle();
    idle_inputs();
    push("rsv_wins", SIG_PEND2, 32'd1);
    push("rsv_wr_data", SIG_RD2, 32'h0BAD_F00D);
    cycle();

    // Load 3 and 9, then a full clear that drops writes and reserves.
    we3_i = 1'b1; wa3_i = 5'd3; wd3_i = 32'h3333_3333;
    cycle();
    wa3_i = 5'd9; wd3_i = 32'h9999_9999;
    cycle();
    idle_inputs(); ra1_i = 5'd3; ra2_i = 5'd9;
    push("load_rd1", SIG_RD1, 32'h3333_3333);
    push("load_rd2", SIG_RD2, 32'h9999_9999);
    clr_i = 1'b1;
    push("clr_edge_ready", SIG_READY, 32'd1);
    cycle();
    idle_inputs();
    for (int i = 0; i < DEPTH; i++) begin
      we3_i = 1'b1; wa3_i = 5'd3; wd3_i = 32'hFFFF_FFFF;
      rsv_i = 1'b1; rsv_a_i = 5'd9;
      push("clr_ready", SIG_READY, 32'd0);
      push("clr_rd1", SIG_RD1, 32'd0);
      push("clr_pend2", SIG_PEND2, 32'd0);
      cycle();
    end
    idle_inputs();
    push("clr_done_ready", SIG_READY, 32'd1);
    push("clr_rd1_entry3", SIG_RD1, 32'd0);
    push("clr_rd2_entry9", SIG_RD2, 32'd0);
    push("clr_pend2_entry9", SIG_PEND2, 32'd0);
    cycle();
    ra1_i = 5'd5; ra2_i = 5'd7;
    push("clr_rd1_entry5", SIG_RD1, 32'd0);
    push("clr_pend2_entry7", SIG_PEND2, 32'd0);
    cycle();

    // clr_i during a clear restarts the sweep.
    clr_i = 1'b1;
    @(posedge clk); #1;
    clr_i = 1'b0;
    repeat (5) begin @(posedge clk); #1; end
    clr_i = 1'b1;
    @(posedge clk); #1;
    clr_i = 1'b0;
    count_ready("restart_ready");

    // Reset ten cycles into a clear aborts it; ready returns 32 edges after release.
    clr_i = 1'b1;
    @(posedge clk); #1;
    clr_i = 1'b0;
    repeat (10) begin @(posedge clk); #1; end
    rst_ni = 1'b0;
    #1;
    push("midclr_rst_ready", SIG_READY, 32'd0);
    drain();
    @(posedge clk);
    @(negedge clk);
    rst_ni = 1'b1;
    count_ready("midclr_ready");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
